// File: rtl/hamming_window_pkg.sv
// hamming_window_pkg
//   Shared definitions for the Hamming window reader: FSM state encoding
//   and the range of coefficient ROM read latencies the datapath supports.
package hamming_window_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // The delay line is sized from the ROM latency; only these depths are
   // supported by the external coefficient ROM.
   localparam int c_ROM_LATENCY_MIN = 1;
   localparam int c_ROM_LATENCY_MAX = 2;

   function automatic bit rom_latency_legal(input int lat);
      return (lat >= c_ROM_LATENCY_MIN) && (lat <= c_ROM_LATENCY_MAX);
   endfunction

endpackage

// File: rtl/hamming_window_delay.sv
// hamming_window_delay
//   Enable-gated shift register that carries accepted samples alongside the
//   coefficient ROM read so both arrive at the multiplier together.
//   clk, rst : clock, asynchronous active-high reset (clears all stages)
//   en       : shift enable (all stages move together)
//   din      : word entering stage 0
//   dout     : word leaving the last stage
module hamming_window_delay #(
   parameter int c_DEPTH = 2,
   parameter int c_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [c_WIDTH-1:0] din,
   output logic [c_WIDTH-1:0] dout
);

   logic [c_DEPTH-1:0][c_WIDTH-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (en) begin
         sr_d[0] = din;
         for (int i = 1; i < c_DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign dout = sr_q[c_DEPTH-1];

endmodule

// File: rtl/hamming_window_reader.sv
// hamming_window_reader
//   Streams frames of 2^c_ADDR_WIDTH signed samples, multiplying each by the
//   Hamming coefficient read from an external ROM at the sample's frame index.
//   clk, rst           : clock, asynchronous active-high reset
//   en                 : run request, honoured only at frame boundaries
//   s_valid/s_ready/s_data : input sample stream
//   m_valid/m_ready/m_data/m_last : windowed output stream, m_last on idx max
//   rom_addr/rom_clk_en/rom_rd_data : external coefficient ROM port
module hamming_window_reader
   import hamming_window_pkg::*;
#(
   parameter int c_ADDR_WIDTH  = 10,
   parameter int c_DATA_WIDTH  = 16,
   parameter int c_COEF_WIDTH  = 16,
   parameter int c_ROM_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [c_DATA_WIDTH-1:0] s_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [c_DATA_WIDTH-1:0] m_data,
   output logic                    m_last,
   output logic [c_ADDR_WIDTH-1:0] rom_addr,
   output logic                    rom_clk_en,
   input  logic [c_COEF_WIDTH-1:0] rom_rd_data
);

   if (!rom_latency_legal(c_ROM_LATENCY)) begin : g_bad_latency
      $error("hamming_window_reader: c_ROM_LATENCY must be 1 or 2");
   end

   localparam logic [c_ADDR_WIDTH-1:0] c_IDX_MAX = '1;
   localparam int c_PROD_W = c_DATA_WIDTH + c_COEF_WIDTH;
   localparam int c_DL_W   = c_DATA_WIDTH + 2;
   // Half an LSB of the Q0.c_COEF_WIDTH product, for round-half-up.
   localparam logic signed [c_PROD_W-1:0] c_ROUND = c_PROD_W'(1) << (c_COEF_WIDTH - 1);

   state_t                  state_q, state_d;
   logic [c_ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                    m_valid_q, m_valid_d;
   logic                    m_last_q, m_last_d;
   logic [c_DATA_WIDTH-1:0] m_data_q, m_data_d;

   logic adv, accept, at_last;

   // A held output freezes everything upstream, including the ROM, so the
   // ROM data stays aligned with the delay line.
   assign adv     = !m_valid_q || m_ready;
   assign accept  = s_valid && s_ready;
   assign at_last = (idx_q == c_IDX_MAX);

   assign rom_addr   = idx_q;
   assign rom_clk_en = adv;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en) state_d = ST_RUN;
         // en is only looked at as the frame closes, so a frame always completes.
         ST_RUN:  if (accept && at_last && !en) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state_q == ST_RUN) && adv;
   end

   // ---------------- frame index ----------------
   // Natural wrap at 2^c_ADDR_WIDTH returns idx to 0 at every frame end.
   always_comb begin
      idx_d = idx_q;
      if (accept) idx_d = idx_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idx_q <= '0;
      else     idx_q <= idx_d;
   end

   // ---------------- sample delay line ----------------
   logic [c_DL_W-1:0]       dl_in, dl_out;
   logic                    dl_valid, dl_last;
   logic [c_DATA_WIDTH-1:0] dl_data;

   assign dl_in = {accept, at_last, s_data};

   hamming_window_delay #(
      .c_DEPTH (c_ROM_LATENCY),
      .c_WIDTH (c_DL_W)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .din  (dl_in),
      .dout (dl_out)
   );

   assign {dl_valid, dl_last, dl_data} = dl_out;

   // ---------------- window multiply ----------------
   // The coefficient gets zero-extended so the signed multiply treats it as
   // unsigned; the product plus rounding always fits c_PROD_W bits.
   logic signed [c_PROD_W-1:0] samp_ext, coef_ext, rnd_sum;
   logic [c_DATA_WIDTH-1:0]    win;

   assign samp_ext = {{c_COEF_WIDTH{dl_data[c_DATA_WIDTH-1]}}, dl_data};
   assign coef_ext = {{c_DATA_WIDTH{1'b0}}, rom_rd_data};
   assign rnd_sum  = samp_ext * coef_ext + c_ROUND;
   assign win      = c_DATA_WIDTH'(rnd_sum >>> c_COEF_WIDTH);

   // ---------------- output register ----------------
   always_comb begin
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      if (adv) begin
         m_valid_d = dl_valid;
         m_last_d  = dl_valid && dl_last;
         if (dl_valid) m_data_d = win;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_data  = m_data_q;

endmodule

// File: doc/hamming_window_reader.md
HAMMING_WINDOW_READER -- requirements
Module: hamming_window_reader

Interface
REQ-001 The module SHALL have parameter c_ADDR_WIDTH, default 10, which sets the frame length to 2^c_ADDR_WIDTH samples and the coefficient ROM address width.
REQ-002 The module SHALL have parameter c_DATA_WIDTH, default 16, the signed sample width for input and output.
REQ-003 The module SHALL have parameter c_COEF_WIDTH, default 16, the unsigned Q0.c_COEF_WIDTH coefficient width.
REQ-004 The module SHALL have parameter c_ROM_LATENCY, default 2, the ROM read latency in enabled cycles; the only legal values are 1 and 2.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port en, input, 1 bit: run request, sampled only at frame boundaries.
REQ-008 The module SHALL have port s_valid, input, 1 bit: input sample valid.
REQ-009 The module SHALL have port s_ready, output, 1 bit: input sample accepted when s_valid and s_ready are both high.
REQ-010 The module SHALL have port s_data, input, c_DATA_WIDTH bits: signed input sample.
REQ-011 The module SHALL have port m_valid, output, 1 bit: output sample valid.
REQ-012 The module SHALL have port m_ready, input, 1 bit: downstream ready.
REQ-013 The module SHALL have port m_data, output, c_DATA_WIDTH bits: windowed signed sample.
REQ-014 The module SHALL have port m_last, output, 1 bit: marks the last sample of a frame.
REQ-015 The module SHALL have port rom_addr, output, c_ADDR_WIDTH bits: coefficient ROM address.
REQ-016 The module SHALL have port rom_clk_en, output, 1 bit: coefficient ROM clock enable.
REQ-017 The module SHALL have port rom_rd_data, input, c_COEF_WIDTH bits: coefficient ROM read data.

Function
REQ-018 Pipeline advance SHALL be defined as adv = !m_valid || m_ready, and rom_clk_en SHALL equal adv.
REQ-019 FSM states SHALL be IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE when en=0 on the cycle the frame's last sample (idx=2^c_ADDR_WIDTH-1) is accepted.
REQ-020 s_ready SHALL be high only while the FSM is in RUN and adv=1, and SHALL be low while in IDLE.
REQ-021 The index counter idx SHALL drive rom_addr combinationally, increment by 1 on each accepted sample, and wrap from 2^c_ADDR_WIDTH-1 to 0.
REQ-022 Deasserting en mid-frame SHALL NOT stop acceptance; the frame SHALL complete, and the FSM SHALL then enter IDLE with idx=0.
REQ-023 Each accepted sample and its last flag (idx=max) SHALL travel through a c_ROM_LATENCY-deep shift register that advances only when adv=1, aligned with rom_rd_data.
REQ-024 The windowed result SHALL be the signed×unsigned product, plus 2^(c_COEF_WIDTH-1), arithmetically shifted right by c_COEF_WIDTH, then truncated to c_DATA_WIDTH; no saturation is required because coef<1.
REQ-025 m_data, m_last and m_valid SHALL be registered; latency from sample acceptance to m_valid SHALL be c_ROM_LATENCY+1 cycles when m_ready stays high.
REQ-026 When m_valid=1 and m_ready=0, m_data and m_last SHALL hold, and no pipeline stage or ROM read SHALL advance.
REQ-027 Sustained throughput SHALL be 1 sample per cycle when s_valid and m_ready are held high.
REQ-028 Pipeline bubbles (s_valid=0 while adv=1) SHALL propagate as invalid stages and SHALL NOT advance idx.

Reset
REQ-029 On rst, the module SHALL asynchronously set state=IDLE, idx=0, all stage valids=0, m_valid=0, m_last=0, and m_data=0.
REQ-030 Assertion of rst mid-frame SHALL discard all in-flight samples; after release, the next frame SHALL start at idx=0.

Structure
REQ-031 The states and the legal c_ROM_LATENCY values SHALL be defined in a shared package, hamming_window_pkg.
REQ-032 The delay line SHALL be one sub-module, hamming_window_delay, which is parameterised by depth and width and has an enable input.
REQ-033 The module SHALL instantiate no ROM; the Hamming coefficient ROM SHALL be connected externally.

Verification
REQ-034 With c_ADDR_WIDTH=3, c_ROM_LATENCY=2, en=1, s_data=16384 streamed continuously and an ideal ROM model, the bench SHALL check m_data=(16384*coef[i]+32768)>>16 with the first output 3 cycles after the first accept, and m_last on the 8th output.
REQ-035 With s_data=-32768 and coef=65535, the bench SHALL check m_data=-32767.
REQ-036 With m_ready held 0 for 5 cycles mid-frame, the bench SHALL check that m_data holds, rom_clk_en=0, and the output sequence afterwards has no loss or duplication.
REQ-037 With en dropped at idx=3, the bench SHALL check that samples 4..7 are still accepted, then s_ready=0, and that en reasserted restarts at rom_addr=0.
REQ-038 With rst asserted at idx=5 with 3 samples in flight, the bench SHALL check that m_valid=0 immediately and the next output corresponds to idx=0.
REQ-039 With c_ROM_LATENCY=1, the bench SHALL check that latency is 2 cycles and the result matches the reference model.
